// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg -- shared definitions for the radix-2 FFT sequencing controller.
//
// Contents:
//   fft_state_e : controller states (LOAD, COMPUTE, DRAIN)
//   bitrev      : reverse the low nbits bits of a value
//   agu_a       : butterfly upper address for (stage s, butterfly i)
//   agu_b       : butterfly lower address, agu_a + 2^s
//   agu_tw      : twiddle ROM address for (stage s, butterfly i)
//
// The functions work on 32-bit unsigned values so they can serve any
// point count; callers cast the result to their own address width.
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } fft_state_e;

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < nbits; b++) begin
            r = r | (((v >> b) & 32'd1) << (nbits - 1 - b));
        end
        return r;
    endfunction

    // Insert a zero at bit position s of i: the low s bits stay in place,
    // the remaining bits move up by one.
    function automatic int unsigned agu_a(input int unsigned s, input int unsigned i);
        return ((i >> s) << (s + 1)) | (i & ((32'd1 << s) - 1));
    endfunction

    function automatic int unsigned agu_b(input int unsigned s, input int unsigned i);
        return agu_a(s, i) + (32'd1 << s);
    endfunction

    function automatic int unsigned agu_tw(input int unsigned s, input int unsigned i,
                                           input int unsigned n2);
        return (i & ((32'd1 << s) - 1)) << (n2 - 1 - s);
    endfunction

endpackage

// File: rtl/fft_agu.sv
// -----------------------------------------------------------------------------
// fft_agu -- combinational address generator for one butterfly.
//
// Ports:
//   i_stage   in  SW     current stage s (0 .. N_2-1)
//   i_idx     in  N_2-1  butterfly index i within the stage (0 .. N/2-1)
//   o_adr_a   out N_2    upper butterfly address A
//   o_adr_b   out N_2    lower butterfly address B = A + 2^s
//   o_twiddle out N_2-1  twiddle ROM address
// -----------------------------------------------------------------------------
module fft_agu
    import fft_pkg::*;
#(
    parameter  int N_2 = 5,
    localparam int SW  = $clog2(N_2)
) (
    input  logic [SW-1:0]  i_stage,
    input  logic [N_2-2:0] i_idx,
    output logic [N_2-1:0] o_adr_a,
    output logic [N_2-1:0] o_adr_b,
    output logic [N_2-2:0] o_twiddle
);

    always_comb begin
        o_adr_a   = N_2'(agu_a(32'(i_stage), 32'(i_idx)));
        o_adr_b   = N_2'(agu_b(32'(i_stage), 32'(i_idx)));
        o_twiddle = (N_2-1)'(agu_tw(32'(i_stage), 32'(i_idx), N_2));
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl -- sequencing controller for an in-place, ping-pong radix-2
// DIT FFT built around two dual-port RAMs (combinational read, registered
// write) and an external butterfly datapath.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   clear                 synchronous abort back to LOAD
//   in_valid / in_ready   input sample handshake (samples go to RAM0)
//   out_valid / out_ready output sample handshake; out_last marks index N-1
//   rd0a, rd1a            RAM port-a read data, used for output streaming
//   out_data              result sample from whichever RAM the last stage wrote
//   load                  selects input data as the RAM0 write data
//   rdsel                 butterfly reads RAM1 when 1, RAM0 when 0
//   we0, we1              RAM write enables
//   adr0a/adr0b/adr1a/adr1b RAM port addresses
//   twiddleadr            twiddle ROM address
//   busy                  high in COMPUTE and DRAIN
//   done                  one-cycle pulse on the final output handshake
//
// Flow: LOAD writes samples in bit-reversed order into RAM0, COMPUTE runs
// N_2 stages of N/2 butterflies (one per cycle) alternating RAM0->RAM1 on
// even stages and RAM1->RAM0 on odd stages, DRAIN streams the result RAM in
// natural order.
// -----------------------------------------------------------------------------
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    input  logic [2*width-1:0] rd0a,
    input  logic [2*width-1:0] rd1a,
    output logic [2*width-1:0] out_data,
    output logic               load,
    output logic               rdsel,
    output logic               we0,
    output logic               we1,
    output logic [N_2-1:0]     adr0a,
    output logic [N_2-1:0]     adr0b,
    output logic [N_2-1:0]     adr1a,
    output logic [N_2-1:0]     adr1b,
    output logic [N_2-2:0]     twiddleadr,
    output logic               busy,
    output logic               done
);

    localparam int            SW     = $clog2(N_2);
    localparam logic [SW-1:0] S_LAST = SW'(N_2 - 1);

    fft_state_e     r_state;
    logic [N_2-1:0] r_k;   // input sample count
    logic [N_2-2:0] r_i;   // butterfly index within the stage
    logic [SW-1:0]  r_s;   // stage
    logic [N_2-1:0] r_j;   // output sample count

    logic [N_2-1:0] w_adr_a;
    logic [N_2-1:0] w_adr_b;
    logic [N_2-2:0] w_tw;
    logic [N_2-1:0] w_k_rev;
    logic           w_live;

    fft_agu #(.N_2(N_2)) u_agu (
        .i_stage   (r_s),
        .i_idx     (r_i),
        .o_adr_a   (w_adr_a),
        .o_adr_b   (w_adr_b),
        .o_twiddle (w_tw)
    );

    assign w_k_rev = N_2'(bitrev(32'(r_k), N_2));

    // Write enables and done are combinational, so they must be gated
    // directly by reset and clear to stay quiet in the cycle those are seen.
    assign w_live = reset && !clear;

    // With an odd number of stages the last (even) stage writes RAM1.
    assign out_data = (N_2 % 2 == 1) ? rd1a : rd0a;

    // NOTE: state and counters use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
            r_i     <= '0;
            r_s     <= '0;
            r_j     <= '0;
        end else if (clear) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
            r_i     <= '0;
            r_s     <= '0;
            r_j     <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    // in_ready is constant 1 here, so in_valid is the handshake.
                    if (in_valid) begin
                        if (r_k == '1) begin
                            r_k     <= '0;
                            r_state <= ST_COMPUTE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_i == '1) begin
                        r_i <= '0;
                        if (r_s == S_LAST) begin
                            r_s     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_j == '1) begin
                            r_j     <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        rdsel      = 1'b0;
        we0        = 1'b0;
        we1        = 1'b0;
        adr0a      = '0;
        adr0b      = '0;
        adr1a      = '0;
        adr1b      = '0;
        twiddleadr = '0;
        busy       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                adr0a    = w_k_rev;
                adr0b    = w_k_rev;
                we0      = in_valid && w_live;
                load     = in_valid && w_live;
            end
            ST_COMPUTE: begin
                busy       = 1'b1;
                adr0a      = w_adr_a;
                adr1a      = w_adr_a;
                adr0b      = w_adr_b;
                adr1b      = w_adr_b;
                twiddleadr = w_tw;
                // Even stages read RAM0 and write RAM1; odd stages the reverse.
                rdsel      = r_s[0];
                we0        = r_s[0] && w_live;
                we1        = !r_s[0] && w_live;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                adr0a     = r_j;
                adr1a     = r_j;
                out_last  = (r_j == '1);
                done      = (r_j == '1) && out_ready && w_live;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_seq_ctrl -- self-checking bench for fft_seq_ctrl (N_2 = 5, N = 32).
//
// The bench owns the two RAMs and a stand-in butterfly that uses unit
// twiddles (X = a + b, Y = a - b per 16-bit component). With unit twiddles the
// whole transform collapses to a Walsh-Hadamard sum, so the reference model
// computes each output directly:
//     y[q] = sum_k x[k] * (-1)^popcount(bitrev(k) & q)
// Controller addressing is checked per cycle against the stage/butterfly
// numbering derived from a plain COMPUTE cycle count.
// -----------------------------------------------------------------------------
module tb_fft_seq_ctrl;

    localparam int N_2 = 5;
    localparam int N   = 1 << N_2;
    localparam int H   = N / 2;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] rd0a;
    logic [31:0] rd1a;
    logic [31:0] out_data;
    logic        load;
    logic        rdsel;
    logic        we0;
    logic        we1;
    logic [4:0]  adr0a;
    logic [4:0]  adr0b;
    logic [4:0]  adr1a;
    logic [4:0]  adr1b;
    logic [3:0]  twiddleadr;
    logic        busy;
    logic        done;

    logic [31:0] in_data;
    logic [31:0] ram0 [N];
    logic [31:0] ram1 [N];
    logic [31:0] frame [N];
    logic [31:0] bf_a;
    logic [31:0] bf_b;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    fft_seq_ctrl #(.width(16), .N_2(N_2)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .rd0a       (rd0a),
        .rd1a       (rd1a),
        .out_data   (out_data),
        .load       (load),
        .rdsel      (rdsel),
        .we0        (we0),
        .we1        (we1),
        .adr0a      (adr0a),
        .adr0b      (adr0b),
        .adr1a      (adr1a),
        .adr1b      (adr1b),
        .twiddleadr (twiddleadr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAMs and unit-twiddle butterfly ----------------
    assign rd0a = ram0[adr0a];
    assign rd1a = ram1[adr1a];
    assign bf_a = rdsel ? ram1[adr1a] : ram0[adr0a];
    assign bf_b = rdsel ? ram1[adr1b] : ram0[adr0b];

    function automatic logic [31:0] addsub(input logic [31:0] a, input logic [31:0] b,
                                           input bit neg);
        logic [15:0] re;
        logic [15:0] im;
        re = neg ? a[31:16] - b[31:16] : a[31:16] + b[31:16];
        im = neg ? a[15:0]  - b[15:0]  : a[15:0]  + b[15:0];
        return {re, im};
    endfunction

    always @(posedge clk) begin
        if (we0) begin
            ram0[adr0a] <= load ? in_data : addsub(bf_a, bf_b, 1'b0);
            ram0[adr0b] <= load ? in_data : addsub(bf_a, bf_b, 1'b1);
        end
        if (we1) begin
            ram1[adr1a] <= addsub(bf_a, bf_b, 1'b0);
            ram1[adr1b] <= addsub(bf_a, bf_b, 1'b1);
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < N_2; b++) begin
            if (v & (1 << b)) r = r + (1 << (N_2 - 1 - b));
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_out(input int q);
        logic [15:0] re;
        logic [15:0] im;
        re = '0;
        im = '0;
        for (int k = 0; k < N; k++) begin
            if ($countones(ref_bitrev(k) & q) % 2 == 1) begin
                re = re - frame[k][31:16];
                im = im - frame[k][15:0];
            end else begin
                re = re + frame[k][31:16];
                im = im + frame[k][15:0];
            end
        end
        return {re, im};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic load_frame();
        int   k;
        int   idle;
        bit   hs;
        logic [4:0] rb;
        k    = 0;
        idle = 0;
        while (k < N) begin
            @(negedge clk);
            hs       = (idle >= 2) || ($urandom_range(3) != 0);
            idle     = hs ? 0 : idle + 1;
            in_valid = hs;
            in_data  = frame[k];
            rb       = 5'(ref_bitrev(k));
            #1;
            check("load", {in_ready, we0, we1, load, busy, out_valid, adr0a, adr0b},
                  {1'b1, hs, 1'b0, hs, 1'b0, 1'b0, rb, rb});
            if (hs && k == 1)  check("load_k1_adr",  {27'd0, adr0a}, 32'd16);
            if (hs && k == 3)  check("load_k3_adr",  {27'd0, adr0a}, 32'd24);
            if (hs && k == 31) check("load_k31_adr", {27'd0, adr0a}, 32'd31);
            if (hs) k++;
        end
    endtask

    task automatic run_compute(input int ncyc);
        int s;
        int i;
        int a;
        int b;
        int tw;
        bit odd;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            #1;
            s   = c / H;
            i   = c % H;
            a   = (i / (1 << s)) * (2 << s) + i % (1 << s);
            b   = a + (1 << s);
            tw  = (i % (1 << s)) * (1 << (N_2 - 1 - s));
            odd = (s % 2 == 1);
            check("compute",
                  {busy, in_ready, out_valid, load, rdsel, we0, we1,
                   adr0a, adr1a, adr0b, adr1b, twiddleadr},
                  {1'b1, 1'b0, 1'b0, 1'b0, odd, odd, !odd,
                   5'(a), 5'(a), 5'(b), 5'(b), 4'(tw)});
            if (c == 0)  check("agu_s0_i0",  {adr0a, adr0b, twiddleadr}, {5'd0,  5'd1,  4'd0});
            if (c == 37) check("agu_s2_i5",  {adr0a, adr0b, twiddleadr}, {5'd9,  5'd13, 4'd4});
            if (c == 79) check("agu_s4_i15", {adr0a, adr0b, twiddleadr}, {5'd15, 5'd31, 4'd15});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_frame();
        int   j;
        int   cyc;
        bit   rdy;
        bit   last;
        logic [3:0] pat;
        j        = 0;
        cyc      = 0;
        pat      = 4'b1001;   // out_ready = 1,0,0,1 on the first four cycles
        done_cnt = 0;
        while (j < N && cyc < 400) begin
            @(negedge clk);
            rdy       = (cyc < 4) ? pat[cyc] : 1'($urandom_range(1));
            out_ready = rdy;
            #1;
            last = (j == N - 1);
            check("drain",
                  {out_valid, in_ready, busy, we0, we1, out_last, done, adr1a, out_data},
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, last, rdy && last, 5'(j), ref_out(j)});
            if (done) done_cnt++;
            if (rdy) j++;
            cyc++;
        end
        check("drain_complete", 128'(j), 128'(N));
        @(negedge clk);
        out_ready = 1'($urandom_range(1));
        #1;
        check("back_to_load", {in_ready, busy, out_valid, done}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("done_once", 128'(done_cnt), 128'd1);
        out_ready = 1'b0;
    endtask

    task automatic random_frame();
        for (int k = 0; k < N; k++) frame[k] = $urandom;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;     // held high through reset to show writes stay gated
        out_ready = 1'b1;
        in_data   = 32'hdead_beef;
        #12;
        check("reset_ready", {127'd0, in_ready}, 128'd1);
        check("reset_ctrl", {out_valid, out_last, done, busy, we0, we1, load, rdsel}, 8'd0);
        check("reset_adr", {adr0a, adr0b, adr1a, adr1b, twiddleadr}, 24'd0);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Random frame, full transform with backpressure.
        random_frame();
        load_frame();
        run_compute(N_2 * H);
        drain_frame();

        // clear together with a handshake during LOAD: no write, k restarts.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("clear_load_nowrite", {we0, we1, load, in_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;

        // Impulse frame end-to-end: every output equals x[0].
        for (int k = 0; k < N; k++) frame[k] = 32'h0;
        frame[0] = 32'h0100_0000;
        load_frame();
        run_compute(N_2 * H);
        drain_frame();

        // clear at COMPUTE cycle 40 together with in_valid.
        random_frame();
        load_frame();
        run_compute(40);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("clear_compute_nowrite", {we0, we1}, 2'b00);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        #1;
        check("clear_next_hs", {in_ready, busy, out_valid, we0, adr0a}, {1'b1, 1'b0, 1'b0, 1'b1, 5'd0});
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clear    = 1'b0;

        // Reset mid-COMPUTE.
        random_frame();
        load_frame();
        run_compute(10);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("midreset_ctrl",
              {in_ready, out_valid, out_last, done, busy, we0, we1, load, rdsel},
              {1'b1, 8'd0});
        check("midreset_adr", {adr0a, adr0b, adr1a, adr1b, twiddleadr}, 24'd0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;

        // Recovery: another full random transform.
        random_frame();
        load_frame();
        run_compute(N_2 * H);
        drain_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
